// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
//   fetch_entry_t : one queued {pc, instruction} pair
//   is_pow2()     : elaboration-time check for legal queue depths
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package fetch_pkg;

  localparam int unsigned WordW  = `WORD;
  localparam int unsigned InstrW = `INSTR_LEN;

  typedef struct packed {
    logic [WordW-1:0]  pc;
    logic [InstrW-1:0] instruction;
  } fetch_entry_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_ring_ptr.sv
// Modulo-Depth ring pointer used for the queue read and write positions.
//   clk     : system clock
//   reset   : synchronous active-high, pointer returns to 0
//   clear_i : synchronous clear to 0 (lower priority than reset)
//   inc_i   : advance by one, wrapping at Depth
//   ptr_o   : current pointer value
module ring_ptr #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Depth is a power of two, so the natural binary wrap is modulo Depth.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a circular FIFO of
// {pc, instruction} entries with valid/ready on both sides and a flush for
// branch redirects.
//   clk, reset                    : clock, synchronous active-high reset
//   flush                         : drop every queued entry (and any same-cycle push/pop)
//   in_valid/in_ready/in_pc/
//   in_instruction                : fetch-side handshake and entry
//   out_valid/out_ready/out_pc/
//   out_instruction               : decode-side handshake and head entry
//   count                         : number of occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WORD      = `WORD,
  parameter int unsigned INSTR_LEN = `INSTR_LEN,
  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD-1:0]      in_pc,
  input  logic [INSTR_LEN-1:0] in_instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_pc,
  output logic [INSTR_LEN-1:0] out_instruction,
  output logic [CntW-1:0]      count
);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and >= 2");
  end
  if (WORD != WordW || INSTR_LEN != InstrW) begin : g_bad_width
    $error("fetch_queue: WORD/INSTR_LEN must match the fetch_entry_t widths");
  end

  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_entry_t    storage_q [DEPTH];
  fetch_entry_t    in_entry;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic            push, pop;

  assign in_ready  = (count_q < Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign in_entry  = '{pc: in_pc, instruction: in_instruction};

  // Flush zeroes both pointers; that keeps rd_ptr == wr_ptr without a load port.
  ring_ptr #(
    .Depth (DEPTH)
  ) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (push),
    .ptr_o   (wr_ptr)
  );

  ring_ptr #(
    .Depth (DEPTH)
  ) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        storage_q[wr_ptr] <= in_entry;
      end
    end
  end

  // Head is read straight from storage: no in_* to out_* combinational path.
  assign out_pc          = storage_q[rd_ptr].pc;
  assign out_instruction = storage_q[rd_ptr].instruction;
  assign count           = count_q;

endmodule
